// File: rtl/predictor_scheduler.sv
// Branch-predictor table scheduler: arbitrates one single-ported 2-bit counter
// table between icache lookups, queued reorder-buffer updates and power-on init.
module predictor_scheduler #(
  parameter int LOCAL_WIDTH = 12,
  parameter int QUEUE_LOG   = 2
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   lookupValid,
  input  logic [31:0]            lookupAddr,
  output logic                   lookupReady,
  input  logic                   updateValid,
  input  logic [31:0]            updateAddr,
  input  logic                   updateTaken,
  output logic                   updateReady,
  output logic                   tableEnable,
  output logic                   tableWrite,
  output logic [LOCAL_WIDTH-1:0] tableIndex,
  output logic [1:0]             tableWriteData,
  input  logic [1:0]             tableReadData,
  output logic                   predictValid,
  output logic                   predictJump,
  output logic                   busy
);

  localparam int                     DEPTH    = 1 << QUEUE_LOG;
  localparam logic [QUEUE_LOG:0]     DEPTH_C  = DEPTH[QUEUE_LOG:0];
  localparam logic [LOCAL_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {INIT, IDLE, UPD_WRITE} state_e;

  typedef struct packed {
    logic [LOCAL_WIDTH-1:0] idx;
    logic                   taken;
  } upd_t;

  state_e                 state_q, state_d;
  logic [LOCAL_WIDTH-1:0] init_idx_q, init_idx_d;
  logic                   pred_q, pred_d;
  upd_t                   queue_q [DEPTH];
  logic [QUEUE_LOG-1:0]   wr_ptr_q, rd_ptr_q;
  logic [QUEUE_LOG:0]     count_q;

  logic                   q_full, q_empty, enq, deq;
  logic                   en, busy_c;
  logic [LOCAL_WIDTH-1:0] lookup_idx, update_idx;
  upd_t                   head;
  logic                   unused_addr_bits;

  assign lookup_idx = lookupAddr[LOCAL_WIDTH+1:2];
  assign update_idx = updateAddr[LOCAL_WIDTH+1:2];
  assign unused_addr_bits = ^{lookupAddr[31:LOCAL_WIDTH+2], lookupAddr[1:0],
                              updateAddr[31:LOCAL_WIDTH+2], updateAddr[1:0]};

  assign q_full      = (count_q == DEPTH_C);
  assign q_empty     = (count_q == '0);
  assign updateReady = !q_full;
  assign enq         = updateValid && !q_full;
  assign head        = queue_q[rd_ptr_q];

  always_comb begin
    state_d        = state_q;
    init_idx_d     = init_idx_q;
    pred_d         = 1'b0;
    deq            = 1'b0;
    en             = 1'b0;
    busy_c         = 1'b0;
    lookupReady    = 1'b0;
    tableWrite     = 1'b0;
    tableIndex     = init_idx_q;
    tableWriteData = 2'b01;
    unique case (state_q)
      INIT: begin
        en         = 1'b1;
        tableWrite = 1'b1;
        busy_c     = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        // Lookups win unless the queue is full; then the head update drains.
        if (lookupValid && !q_full) begin
          lookupReady = 1'b1;
          en          = 1'b1;
          tableIndex  = lookup_idx;
          pred_d      = 1'b1;
        end else if (!q_empty) begin
          en         = 1'b1;
          tableIndex = head.idx;
          state_d    = UPD_WRITE;
        end
      end
      UPD_WRITE: begin
        en         = 1'b1;
        tableWrite = 1'b1;
        tableIndex = head.idx;
        deq        = 1'b1;
        state_d    = IDLE;
        if (head.taken)
          tableWriteData = (tableReadData == 2'b11) ? 2'b11 : tableReadData + 2'd1;
        else
          tableWriteData = (tableReadData == 2'b00) ? 2'b00 : tableReadData - 2'd1;
      end
      default: state_d = INIT;
    endcase
  end

  // State resets to INIT asynchronously, so gate the INIT-driven strobes
  // while reset is held to keep the table quiet.
  assign tableEnable  = en && resetIn;
  assign busy         = busy_c && resetIn;
  assign predictValid = pred_q;
  assign predictJump  = pred_q && tableReadData[1];

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      pred_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      pred_q     <= pred_d;
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (enq) queue_q[wr_ptr_q] <= '{idx: update_idx, taken: updateTaken};
  end

endmodule

// File: tb/tb_predictor_scheduler.sv
// Directed bench for predictor_scheduler (LOCAL_WIDTH=4, QUEUE_LOG=2) with a
// behavioural counter table that returns read data one cycle after a read.
module tb_predictor_scheduler;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetIn;
  logic          lookupValid;
  logic [31:0]   lookupAddr;
  logic          lookupReady;
  logic          updateValid;
  logic [31:0]   updateAddr;
  logic          updateTaken;
  logic          updateReady;
  logic          tableEnable;
  logic          tableWrite;
  logic [LW-1:0] tableIndex;
  logic [1:0]    tableWriteData;
  logic [1:0]    tableReadData;
  logic          predictValid;
  logic          predictJump;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] mem [1 << LW];

  always #5 clk = ~clk;

  predictor_scheduler #(.LOCAL_WIDTH(LW), .QUEUE_LOG(2)) dut (
    .clockIn(clk), .resetIn(resetIn),
    .lookupValid(lookupValid), .lookupAddr(lookupAddr), .lookupReady(lookupReady),
    .updateValid(updateValid), .updateAddr(updateAddr), .updateTaken(updateTaken),
    .updateReady(updateReady),
    .tableEnable(tableEnable), .tableWrite(tableWrite), .tableIndex(tableIndex),
    .tableWriteData(tableWriteData), .tableReadData(tableReadData),
    .predictValid(predictValid), .predictJump(predictJump), .busy(busy)
  );

  always @(posedge clk) begin
    if (tableEnable) begin
      if (tableWrite) mem[tableIndex] <= tableWriteData;
      else            tableReadData   <= mem[tableIndex];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic enq_one(input logic [31:0] addr, input logic taken);
    updateValid = 1'b1; updateAddr = addr; updateTaken = taken;
    next_cycle();
    updateValid = 1'b0;
  endtask

  // Scan a bounded number of cycles for the next table write.
  task automatic expect_write(input string tag, input int idx, input int data);
    bit found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (tableEnable && tableWrite) begin
        found = 1'b1;
        chk({tag, ".idx"}, 32'(tableIndex), idx);
        chk({tag, ".dat"}, 32'(tableWriteData), data);
      end
      next_cycle();
    end
    chk({tag, ".found"}, 32'(found), 1);
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] addr, input int idx, input logic jump);
    lookupValid = 1'b1; lookupAddr = addr;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(lookupReady), 1);
    chk({tag, ".idx"}, 32'(tableIndex), idx);
    next_cycle();
    lookupValid = 1'b0;
    @(negedge clk);
    chk({tag, ".pv"}, 32'(predictValid), 1);
    chk({tag, ".pj"}, 32'(predictJump), 32'(jump));
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << LW); i++) mem[i] = 2'b11;
    tableReadData = 2'b00;
    resetIn = 1'b0; lookupValid = 1'b0; lookupAddr = 32'h0;
    updateValid = 1'b0; updateAddr = 32'h0; updateTaken = 1'b0;
    repeat (3) next_cycle();
    chk("rst.en",   32'(tableEnable), 0);
    chk("rst.lrdy", 32'(lookupReady), 0);
    chk("rst.pv",   32'(predictValid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.urdy", 32'(updateReady), 1);

    // Release with a lookup already pending; it must wait for init to end.
    lookupValid = 1'b1; lookupAddr = 32'h24;
    resetIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("init.en",   32'(tableEnable), 1);
      chk("init.wr",   32'(tableWrite), 1);
      chk("init.idx",  32'(tableIndex), i);
      chk("init.dat",  32'(tableWriteData), 1);
      chk("init.busy", 32'(busy), 1);
      chk("init.lrdy", 32'(lookupReady), 0);
      next_cycle();
    end

    @(negedge clk);
    chk("c17.busy", 32'(busy), 0);
    chk("c17.lrdy", 32'(lookupReady), 1);
    chk("c17.en",   32'(tableEnable), 1);
    chk("c17.wr",   32'(tableWrite), 0);
    chk("c17.idx",  32'(tableIndex), 9);
    next_cycle();
    lookupValid = 1'b0;
    @(negedge clk);
    chk("lk24.pv",  32'(predictValid), 1);
    chk("lk24.pj",  32'(predictJump), 0);
    chk("idle.en",  32'(tableEnable), 0);
    next_cycle();
    @(negedge clk);
    chk("lk24.pv0", 32'(predictValid), 0);
    next_cycle();

    enq_one(32'h24, 1'b1); expect_write("tk1", 9, 2);
    enq_one(32'h24, 1'b1); expect_write("tk2", 9, 3);
    enq_one(32'h24, 1'b1); expect_write("tk3", 9, 3);
    do_lookup("lk24b", 32'h24, 9, 1'b1);

    enq_one(32'h08, 1'b0); expect_write("nt1", 2, 0);
    enq_one(32'h08, 1'b0); expect_write("nt2", 2, 0);
    do_lookup("lk08", 32'h08, 2, 1'b0);

    // Lookups held high while four updates fill the queue.
    lookupValid = 1'b1; lookupAddr = 32'h24;
    updateValid = 1'b1; updateAddr = 32'h04; updateTaken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fill.urdy", 32'(updateReady), 1);
      chk("fill.lrdy", 32'(lookupReady), 1);
      next_cycle();
    end
    updateValid = 1'b0;
    @(negedge clk);
    chk("full.urdy", 32'(updateReady), 0);
    chk("full.lrdy", 32'(lookupReady), 0);
    chk("full.en",   32'(tableEnable), 1);
    chk("full.wr",   32'(tableWrite), 0);
    chk("full.idx",  32'(tableIndex), 1);
    next_cycle();
    @(negedge clk);
    chk("updw.wr",   32'(tableWrite), 1);
    chk("updw.idx",  32'(tableIndex), 1);
    chk("updw.dat",  32'(tableWriteData), 2);
    chk("updw.lrdy", 32'(lookupReady), 0);
    next_cycle();
    @(negedge clk);
    chk("occ3.urdy", 32'(updateReady), 1);
    chk("occ3.lrdy", 32'(lookupReady), 1);
    next_cycle();

    // Drop lookups so the head drains, then reset in the middle of UPD_WRITE.
    lookupValid = 1'b0;
    @(negedge clk);
    chk("drain.en", 32'(tableEnable), 1);
    chk("drain.wr", 32'(tableWrite), 0);
    @(posedge clk); #2;
    chk("upd.wr",   32'(tableWrite), 1);
    resetIn = 1'b0;
    #1;
    chk("arst.en",   32'(tableEnable), 0);
    chk("arst.lrdy", 32'(lookupReady), 0);
    chk("arst.pv",   32'(predictValid), 0);
    chk("arst.pj",   32'(predictJump), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.urdy", 32'(updateReady), 1);
    next_cycle();
    resetIn = 1'b1;
    @(negedge clk);
    chk("rinit.en",   32'(tableEnable), 1);
    chk("rinit.wr",   32'(tableWrite), 1);
    chk("rinit.idx",  32'(tableIndex), 0);
    chk("rinit.dat",  32'(tableWriteData), 1);
    chk("rinit.busy", 32'(busy), 1);
    next_cycle();
    @(negedge clk);
    chk("rinit.idx1", 32'(tableIndex), 1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
